// File: rtl/bcd_to_bin.sv
// Packed-BCD to binary converter using reverse double-dabble, one bit per clock.
// A start in IDLE latches the operand. A word containing any digit above 9 is
// rejected on the same edge with an err/done pulse. Every other word is
// converted in W shift cycles.
module bcd_to_bin #(
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [4*DIGITS-1:0]   binary_out
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(W + 1);

  // state | meaning
  // IDLE  | waiting for start; done/err pulse cycles are spent here
  // SHIFT | one reverse double-dabble step per clock, W steps in total
  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state, state_next;
  logic [W-1:0]    bcd_reg, bin_reg;
  logic [CW-1:0]   cnt;
  logic            bad_digit;
  logic            last_shift;
  logic [W-1:0]    bcd_shift, bcd_fix, bin_shift;

  // Flag any non-decimal digit on the operand being offered at start
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // One shift step: move the BCD LSB into the binary MSB, then pull each digit >= 8 back by 3
  always_comb begin
    bin_shift = {bcd_reg[0], bin_reg[W-1:1]};
    bcd_shift = {1'b0, bcd_reg[W-1:1]};
    bcd_fix   = bcd_shift;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_shift[4*i +: 4] >= 4'd8) bcd_fix[4*i +: 4] = bcd_shift[4*i +: 4] - 4'd3;
    end
  end

  assign last_shift = (cnt == CW'(W - 1));

  // State register and datapath; done is a registered one-cycle pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      done       <= 1'b0;
      err        <= 1'b0;
      binary_out <= '0;
      bcd_reg    <= '0;
      bin_reg    <= '0;
      cnt        <= '0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bcd_reg <= bcd_in;
            bin_reg <= '0;
            cnt     <= '0;
            if (bad_digit) begin
              done       <= 1'b1;
              err        <= 1'b1;
              binary_out <= '0;
            end else begin
              err <= 1'b0;
            end
          end
        end
        SHIFT: begin
          bcd_reg <= bcd_fix;
          bin_reg <= bin_shift;
          cnt     <= cnt + CW'(1);
          if (last_shift) begin
            binary_out <= bin_shift;
            done       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && !bad_digit) state_next = SHIFT;
      SHIFT:   if (last_shift) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Busy is exactly the SHIFT phase
  always_comb begin
    busy = (state == SHIFT);
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
module tb_bcd_to_bin;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] bcd_in = '0;
  logic        busy, done, err;
  logic [31:0] binary_out;

  int n_chk  = 0;
  int n_pass = 0;

  bcd_to_bin #(.DIGITS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bcd_in     (bcd_in),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .binary_out (binary_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] bcd;
    logic        exp_err;
    logic [31:0] exp_bin;
  } vec_t;

  function automatic bit ref_bad(input logic [31:0] b);
    for (int i = 0; i < 8; i++) if (((b >> (4*i)) & 32'hF) > 9) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_val(input logic [31:0] b);
    longint v = 0;
    for (int i = 7; i >= 0; i--) v = v * 10 + longint'((b >> (4*i)) & 32'hF);
    return ref_bad(b) ? 32'd0 : v[31:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Called at a negedge; leaves at the negedge right after the start edge
  task automatic launch(input logic [31:0] v);
    start  = 1'b1;
    bcd_in = v;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Waits for done, scrambling bcd_in while busy; lat counts negedges after the start edge
  task automatic wait_done(output int lat, output int nbusy, output bit overlap);
    lat = 0; nbusy = 0; overlap = 1'b0;
    while (done !== 1'b1 && lat < 200) begin
      if (busy === 1'b1) nbusy++;
      @(negedge clk);
      bcd_in = $urandom;
      lat++;
    end
    if (busy === 1'b1 && done === 1'b1) overlap = 1'b1;
    if (lat >= 200) chk("done_timeout", 32'(lat), 32'(W));
  endtask

  task automatic do_conv(input logic [31:0] v, input logic exp_err, input logic [31:0] exp_bin,
                         input string name);
    int lat, nb;
    bit ov;
    logic [31:0] held;
    launch(v);
    wait_done(lat, nb, ov);
    chk({name, "_latency"}, 32'(lat), exp_err ? 32'd0 : 32'(W));
    chk({name, "_busy_cycles"}, 32'(nb), exp_err ? 32'd0 : 32'(W));
    chk({name, "_busy_done_overlap"}, {31'd0, ov}, 32'd0);
    chk({name, "_err"}, {31'd0, err}, {31'd0, exp_err});
    chk({name, "_binary_out"}, binary_out, exp_bin);
    held = binary_out;
    @(negedge clk);
    chk({name, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    chk({name, "_held"}, binary_out, held);
  endtask

  vec_t vecs[9];

  initial begin
    int lat, nb, lat2;
    bit ov;
    bit saw_done;

    vecs[0] = '{32'h12345678, 1'b0, 32'h00BC614E};
    vecs[1] = '{32'h99999999, 1'b0, 32'h05F5E0FF};
    vecs[2] = '{32'h00000000, 1'b0, 32'h00000000};
    vecs[3] = '{32'h00000100, 1'b0, 32'h00000064};
    vecs[4] = '{32'h0000001A, 1'b1, 32'h00000000};
    vecs[5] = '{32'h00000042, 1'b0, 32'h0000002A};
    vecs[6] = '{32'hA0000000, 1'b1, 32'h00000000};
    vecs[7] = '{32'h10000000, 1'b0, 32'h00989680};
    vecs[8] = '{32'h00000009, 1'b0, 32'h00000009};

    // Reset then idle
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("idle_outputs", {busy, done, err, binary_out[28:0]}, 32'd0);
      @(negedge clk);
    end

    // Directed table
    for (int i = 0; i < 9; i++)
      do_conv(vecs[i].bcd, vecs[i].exp_err, vecs[i].exp_bin, $sformatf("vec%0d", i));

    // Start while busy is ignored; start in the done cycle is accepted
    launch(32'h00000025);
    repeat (9) @(negedge clk);
    start = 1'b1; bcd_in = 32'h00000099;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, nb, ov);
    chk("ignore_latency", 32'(lat + 10), 32'(W));
    chk("ignore_result", binary_out, 32'h19);
    launch(32'h00000007);
    chk("b2b_done_dropped", {31'd0, done}, 32'd0);
    wait_done(lat2, nb, ov);
    chk("b2b_latency", 32'(lat2), 32'(W));
    chk("b2b_result", binary_out, 32'h07);
    @(negedge clk);

    // Reset mid-conversion aborts without done
    launch(32'h12345678);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_state", {busy, done, err, binary_out[28:0]}, 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_done", {31'd0, saw_done}, 32'd0);
    do_conv(32'h87654321, 1'b0, ref_val(32'h87654321), "after_reset");

    // Randomized operands against the decimal model
    for (int n = 0; n < 30; n++) begin
      logic [31:0] v;
      v = '0;
      for (int d = 0; d < 8; d++) v[4*d +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 4) == 0) v[4*$urandom_range(0, 7) +: 4] = 4'($urandom_range(10, 15));
      do_conv(v, ref_bad(v), ref_val(v), $sformatf("rand%0d_%08h", n, v));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
